// File: rtl/bus_map_pkg.sv
// Shared bus-responder definitions: IO page decode offsets and UART state encoding.
package bus_map_pkg;

  localparam int IO_BIT_DEFAULT = 22;

  localparam logic [2:0] OFF_LEDS      = 3'd0;
  localparam logic [2:0] OFF_UART_DATA = 3'd1;
  localparam logic [2:0] OFF_UART_STAT = 3'd2;
  localparam logic [2:0] OFF_TIMER     = 3'd3;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 serial transmitter; one frame per start pulse, LSB first, idle-high line.
module uart_tx_core
  import bus_map_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_din,
  output logic       o_busy,
  output logic       o_tx
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  // Frame sequencer; the line level is registered alongside the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= UART_IDLE;
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= 8'h00;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        UART_IDLE: begin
          r_tx  <= 1'b1;
          r_cnt <= '0;
          if (i_start) begin
            r_state <= UART_START;
            r_shift <= i_din;
            r_tx    <= 1'b0;
          end
        end
        UART_START: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_state <= UART_DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        UART_DATA: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            if (r_idx == 3'd7) begin
              r_state <= UART_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_tx    <= r_shift[1];
              r_shift <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        UART_STOP: begin
          r_tx <= 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_state <= UART_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= UART_IDLE;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign o_busy = (r_state != UART_IDLE);
  assign o_tx   = r_tx;

endmodule

// File: rtl/bus_responder.sv
// CPU memory-bus target: byte-lane RAM plus IO page (LEDs, timer, UART TX).
// Define UART_TX_EN to build the UART transmitter; otherwise uart_tx idles high.
module bus_responder
  import bus_map_pkg::*;
#(
  parameter int MEM_WORDS   = 1024,
  parameter int IO_BIT      = IO_BIT_DEFAULT,
  parameter int LED_W       = 8,
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD        = 115200
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_mem_addr,
  input  logic [31:0]      i_mem_wdata,
  input  logic             i_mem_rstrb,
  input  logic [3:0]       i_mem_wstrb,
  output logic [31:0]      o_mem_rdata,
  output logic [LED_W-1:0] o_leds,
  output logic             o_uart_tx
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;

  logic [31:0]      r_ram [MEM_WORDS];
  logic [31:0]      r_ram_q;
  logic             r_rd_io;
  logic [31:0]      r_io_q;
  logic [LED_W-1:0] r_leds;
  logic [31:0]      r_timer;
  logic             r_overrun;

  logic          w_is_io;
  logic [AW-1:0] w_ram_idx;
  logic [2:0]    w_io_off;
  logic          w_io_wr;
  logic          w_stat_rd;
  logic          w_busy;
  logic          w_tx;
  logic          w_overrun_nxt;
  logic [31:0]   w_io_rdata;

  assign w_is_io   = i_mem_addr[IO_BIT];
  assign w_ram_idx = i_mem_addr[AW+1:2];
  assign w_io_off  = i_mem_addr[4:2];
  assign w_io_wr   = w_is_io && (i_mem_wstrb != 4'b0000);
  assign w_stat_rd = w_is_io && i_mem_rstrb && (w_io_off == OFF_UART_STAT);

  // Block RAM: per-lane write, read-before-write so a same-edge read sees the old word.
  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (!w_is_io && i_mem_wstrb[b]) begin
        r_ram[w_ram_idx][8*b +: 8] <= i_mem_wdata[8*b +: 8];
      end
    end
    if (i_mem_rstrb) begin
      r_ram_q <= r_ram[w_ram_idx];
    end
  end

  // IO page read mux
  always_comb begin
    w_io_rdata = 32'h0000_0000;
    case (w_io_off)
      OFF_LEDS:      w_io_rdata = 32'(r_leds);
      OFF_UART_STAT: w_io_rdata = {30'h0000_0000, r_overrun, w_busy};
      OFF_TIMER:     w_io_rdata = r_timer;
      default:       w_io_rdata = 32'h0000_0000;
    endcase
  end

`ifdef UART_TX_EN
  logic w_data_wr;
  logic w_start;

  assign w_data_wr     = w_io_wr && (w_io_off == OFF_UART_DATA);
  assign w_start       = w_data_wr && !w_busy;
  // A dropped byte wins over the clearing status read.
  assign w_overrun_nxt = (w_data_wr && w_busy) ? 1'b1 : (w_stat_rd ? 1'b0 : r_overrun);

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_start(w_start),
    .i_din  (i_mem_wdata[7:0]),
    .o_busy (w_busy),
    .o_tx   (w_tx)
  );
`else
  logic w_unused_uart;
  assign w_unused_uart = w_stat_rd ^ (CLKS_PER_BIT > 0);
  assign w_busy        = 1'b0;
  assign w_tx          = 1'b1;
  assign w_overrun_nxt = 1'b0;
`endif

  // IO registers and the read-side select; r_rd_io resets high so the output reads 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_io   <= 1'b1;
      r_io_q    <= 32'h0000_0000;
      r_leds    <= '0;
      r_timer   <= 32'h0000_0000;
      r_overrun <= 1'b0;
    end else begin
      if (i_mem_rstrb) begin
        r_rd_io <= w_is_io;
        r_io_q  <= w_io_rdata;
      end
      if (w_io_wr && (w_io_off == OFF_LEDS)) begin
        r_leds <= i_mem_wdata[LED_W-1:0];
      end
      if (w_io_wr && (w_io_off == OFF_TIMER)) begin
        r_timer <= i_mem_wdata;
      end else begin
        r_timer <= r_timer + 32'd1;
      end
      r_overrun <= w_overrun_nxt;
    end
  end

  assign o_mem_rdata = r_rd_io ? r_io_q : r_ram_q;
  assign o_leds      = r_leds;
  assign o_uart_tx   = w_tx;

endmodule
